// File: rtl/pipe_pkg.sv
// pipe_pkg: shared hazard-control types and encodings
package pipe_pkg;
    typedef enum logic {IDLE, BUSY} mdu_state_t;
    localparam logic [1:0] FWD_RF   = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;
    localparam logic [1:0] RES_LOAD = 2'b01;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);
    logic [W-1:0] count_q, count_d;
    always_comb count_d = clr ? '0 : (inc && !(&count_q)) ? count_q + 1'b1 : count_q;
    always_ff @(posedge clk) begin
        if (!rst_n) count_q <= '0;
        else        count_q <= count_d;
    end
    assign count = count_q;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: forwarding, stall/flush and MDU sequencing for the 5-stage pipeline
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int CNT_W  = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic [REG_AW-1:0] RdM,
    input  logic [REG_AW-1:0] RdW,
    input  logic [1:0]        ResultSrcE,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              PCSrcE,
    input  logic              MulDivE,
    input  logic              mdu_done,
    input  logic              perf_clr,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushM,
    output logic              mdu_start,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_count
);
    mdu_state_t state_q, state_d;
    logic [1:0] fwd_a, fwd_b;
    logic       lw_stall, mdu_stall, idle;

    always_comb begin
        fwd_a     = (Rs1E != '0 && Rs1E == RdM && RegWriteM) ? FWD_MEM :
                    (Rs1E != '0 && Rs1E == RdW && RegWriteW) ? FWD_WB : FWD_RF;
        fwd_b     = (Rs2E != '0 && Rs2E == RdM && RegWriteM) ? FWD_MEM :
                    (Rs2E != '0 && Rs2E == RdW && RegWriteW) ? FWD_WB : FWD_RF;
        lw_stall  = (ResultSrcE == RES_LOAD) && RdE != '0 && (RdE == Rs1D || RdE == Rs2D);
        idle      = state_q == IDLE;
        mdu_stall = idle ? MulDivE : !mdu_done;
        state_d   = idle ? (MulDivE ? BUSY : IDLE) : (mdu_done ? IDLE : BUSY);
        ForwardAE = rst_n ? fwd_a : FWD_RF;
        ForwardBE = rst_n ? fwd_b : FWD_RF;
        StallF    = rst_n && (mdu_stall || lw_stall);
        StallD    = StallF;
        StallE    = rst_n && mdu_stall;
        FlushM    = StallE;
        FlushD    = !rst_n || (PCSrcE && !mdu_stall);
        FlushE    = !rst_n || ((PCSrcE || lw_stall) && !mdu_stall);
        mdu_start = rst_n && idle && MulDivE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk(clk), .rst_n(rst_n), .clr(perf_clr), .inc(StallF), .count(stall_cycles)
    );
    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk(clk), .rst_n(rst_n), .clr(perf_clr), .inc(FlushD), .count(flush_count)
    );
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: vector table plus directed MDU, counter and reset sequences
module tb_hazard_ctrl;
    localparam int CW = 4;
    logic clk = 0, rst_n = 0;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0] ResultSrcE, ForwardAE, ForwardBE;
    logic RegWriteM, RegWriteW, PCSrcE, MulDivE, mdu_done, perf_clr;
    logic StallF, StallD, StallE, FlushD, FlushE, FlushM, mdu_start;
    logic [CW-1:0] stall_cycles, flush_count;
    int total = 0, bad = 0;

    hazard_ctrl #(.CNT_W(CW), .REG_AW(5)) dut (
        .clk(clk), .rst_n(rst_n), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW), .ResultSrcE(ResultSrcE), .RegWriteM(RegWriteM),
        .RegWriteW(RegWriteW), .PCSrcE(PCSrcE), .MulDivE(MulDivE), .mdu_done(mdu_done),
        .perf_clr(perf_clr), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .StallF(StallF),
        .StallD(StallD), .StallE(StallE), .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
        .mdu_start(mdu_start), .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic [1:0] res;
        logic       rwm, rww, pc;
        logic [1:0] fa, fb;
        logic       sf, se, fd, fe, fm;
    } vec_t;
    vec_t v[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic clear_in();
        {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
        ResultSrcE = 2'b00;
        {RegWriteM, RegWriteW, PCSrcE, MulDivE, mdu_done} = '0;
    endtask

    task automatic load_dep(input logic pc);
        ResultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7; PCSrcE = pc;
    endtask

    task automatic chk_ctl(input string tag, input logic sf, input logic se, input logic fd,
                           input logic fe, input logic fm, input logic st);
        chk({tag, ".StallF"}, 32'(StallF), 32'(sf));
        chk({tag, ".StallD"}, 32'(StallD), 32'(sf));
        chk({tag, ".StallE"}, 32'(StallE), 32'(se));
        chk({tag, ".FlushD"}, 32'(FlushD), 32'(fd));
        chk({tag, ".FlushE"}, 32'(FlushE), 32'(fe));
        chk({tag, ".FlushM"}, 32'(FlushM), 32'(fm));
        chk({tag, ".mdu_start"}, 32'(mdu_start), 32'(st));
    endtask

    initial begin
        //        rs1d rs2d rs1e rs2e rde rdm rdw res  rwm rww pc  fa   fb   sf se fd fe fm
        v[0]  = '{0, 0, 5, 0, 0, 5, 5, 2'b00, 1, 1, 0, 2'b10, 2'b00, 0, 0, 0, 0, 0};
        v[1]  = '{0, 0, 5, 0, 0, 0, 5, 2'b00, 1, 1, 0, 2'b01, 2'b00, 0, 0, 0, 0, 0};
        v[2]  = '{0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0};
        v[3]  = '{0, 0, 0, 9, 0, 9, 9, 2'b00, 1, 0, 0, 2'b00, 2'b10, 0, 0, 0, 0, 0};
        v[4]  = '{0, 0, 0, 9, 0, 9, 9, 2'b00, 0, 1, 0, 2'b00, 2'b01, 0, 0, 0, 0, 0};
        v[5]  = '{0, 0, 3, 3, 0, 3, 3, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0};
        v[6]  = '{0, 7, 0, 0, 7, 0, 0, 2'b01, 0, 0, 0, 2'b00, 2'b00, 1, 0, 0, 1, 0};
        v[7]  = '{0, 0, 0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0};
        v[8]  = '{7, 0, 0, 0, 7, 0, 0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0};
        v[9]  = '{7, 0, 0, 0, 7, 0, 0, 2'b01, 0, 0, 0, 2'b00, 2'b00, 1, 0, 0, 1, 0};
        v[10] = '{0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 2'b00, 2'b00, 0, 0, 1, 1, 0};
        v[11] = '{0, 7, 0, 0, 7, 0, 0, 2'b01, 0, 0, 1, 2'b00, 2'b00, 1, 0, 1, 1, 0};

        clear_in();
        perf_clr = 0;
        @(negedge clk);
        MulDivE = 1; load_dep(1'b0); Rs1E = 5; RdM = 5; RegWriteM = 1;
        #1;
        chk("rst.ForwardAE", 32'(ForwardAE), 0);
        chk_ctl("rst", 0, 0, 1, 1, 0, 0);
        @(negedge clk);
        chk("rst.stall_cycles", 32'(stall_cycles), 0);
        chk("rst.flush_count", 32'(flush_count), 0);
        rst_n = 1; perf_clr = 1; clear_in();

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            Rs1D = v[i].rs1d; Rs2D = v[i].rs2d; Rs1E = v[i].rs1e; Rs2E = v[i].rs2e;
            RdE = v[i].rde; RdM = v[i].rdm; RdW = v[i].rdw; ResultSrcE = v[i].res;
            RegWriteM = v[i].rwm; RegWriteW = v[i].rww; PCSrcE = v[i].pc;
            #1;
            chk($sformatf("v%0d.ForwardAE", i), 32'(ForwardAE), 32'(v[i].fa));
            chk($sformatf("v%0d.ForwardBE", i), 32'(ForwardBE), 32'(v[i].fb));
            chk_ctl($sformatf("v%0d", i), v[i].sf, v[i].se, v[i].fd, v[i].fe, v[i].fm, 0);
        end

        @(negedge clk);
        clear_in(); perf_clr = 0; load_dep(1'b0);
        @(negedge clk);
        clear_in();
        chk("lw.stall_cycles", 32'(stall_cycles), 1);
        chk("lw.flush_count", 32'(flush_count), 0);
        PCSrcE = 1;
        #1 chk_ctl("br", 0, 0, 1, 1, 0, 0);
        @(negedge clk);
        clear_in();
        chk("br.flush_count", 32'(flush_count), 1);
        chk("br.stall_cycles", 32'(stall_cycles), 1);

        MulDivE = 1;
        #1 chk_ctl("mdu0", 1, 1, 0, 0, 1, 1);
        for (int c = 1; c < 4; c++) begin
            @(negedge clk);
            #1 chk_ctl($sformatf("mdu%0d", c), 1, 1, 0, 0, 1, 0);
        end
        @(negedge clk);
        mdu_done = 1;
        #1 chk_ctl("mdu_done", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        clear_in();
        #1 chk_ctl("mdu_after", 0, 0, 0, 0, 0, 0);
        chk("mdu.stall_cycles", 32'(stall_cycles), 5);
        chk("mdu.flush_count", 32'(flush_count), 1);

        mdu_done = 1;
        #1 chk_ctl("done_idle", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        clear_in(); MulDivE = 1; load_dep(1'b1);
        #1 chk_ctl("mdu_prio0", 1, 1, 0, 0, 1, 1);
        @(negedge clk);
        #1 chk_ctl("mdu_prio1", 1, 1, 0, 0, 1, 0);
        @(negedge clk);
        rst_n = 0;
        #1 chk_ctl("rst_busy", 0, 0, 1, 1, 0, 0);
        @(negedge clk);
        rst_n = 1; clear_in();
        #1 chk_ctl("post_rst", 0, 0, 0, 0, 0, 0);
        chk("post_rst.stall_cycles", 32'(stall_cycles), 0);
        chk("post_rst.flush_count", 32'(flush_count), 0);

        load_dep(1'b1);
        for (int c = 0; c < 15; c++) @(negedge clk);
        chk("sat15.stall_cycles", 32'(stall_cycles), 15);
        for (int c = 0; c < 3; c++) @(negedge clk);
        chk("sat.stall_cycles", 32'(stall_cycles), 15);
        chk("sat.flush_count", 32'(flush_count), 15);
        perf_clr = 1;
        @(negedge clk);
        clear_in(); perf_clr = 0;
        chk("clr.stall_cycles", 32'(stall_cycles), 0);
        chk("clr.flush_count", 32'(flush_count), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
